ksa_shuffle: RTL and testbench
==============================

// Module: ksa_shuffle
// PURPOSE
//  RC4 key-scheduling stage: permutes the 256-byte S array that the init stage has left as S[i]=i.
//  For i=0..255: j = j + S[i] + key[i mod KEY_LEN]; swap S[i], S[j].
//  Sits directly downstream of the init stage and shares the same single-port S RAM through the arbiter mux.
//  Start/complete handshake identical to the init stage; its complete pulse drives our start.
// PARAMETERS
//  KEY_LEN  3  secret key length in bytes; key byte 0 = secret_key[8*KEY_LEN-1 -: 8] (MSB first)
//  ADDR_W   8  S RAM address width; the array holds 2**ADDR_W bytes; all index arithmetic is mod 2**ADDR_W
// PORTS
//  clk         in   1            system clock, all logic on posedge
//  reset       in   1            asynchronous, active-high reset
//  start       in   1            begin shuffle; sampled only in IDLE
//  secret_key  in   8*KEY_LEN    key; latched into key_r on the accepted start
//  q           in   8            S RAM read data
//  address     out  ADDR_W       S RAM address
//  data        out  8            S RAM write data
//  wren        out  1            S RAM write enable
//  complete    out  1            one-cycle pulse when the permutation is finished
// BEHAVIOUR
//  Reset (async): state=IDLE; i=j=kidx=si=sj=0; address=0, data=0, wren=0, complete=0.
//  RAM read latency: address presented in cycle N; q sampled at the end of cycle N+1 (one wait state).
//  States, one cycle each:
//   IDLE    wren=0. If start: key_r<=secret_key, i<=0, j<=0, kidx<=0 -> RD_I.
//   RD_I    address=i                                                 -> WAIT_I
//   WAIT_I  address=i                                                 -> GET_I
//   GET_I   si<=q; j<=j+q+key_r[kidx] (8-bit, carry dropped)          -> RD_J
//   RD_J    address=j                                                 -> WAIT_J
//   WAIT_J  address=j                                                 -> GET_J
//   GET_J   sj<=q                                                     -> WR_I
//   WR_I    address=i, data=sj, wren=1                                -> WR_J
//   WR_J    address=j, data=si, wren=1. If i==255 -> DONE;
//           else i<=i+1, kidx<=(kidx==KEY_LEN-1)?0:kidx+1 -> RD_I
//   DONE    complete=1                                                -> IDLE
//  Timing: 8 cycles per iteration; complete is high in the 2049th cycle after the start-accept edge.
//  wren is high only in WR_I/WR_J: exactly 512 write cycles per run.
//  No other state asserts wren.
//  Outputs are decoded from the state register and the i/j/si/sj registers only; q never reaches
//  the outputs combinationally.
//  i==j: both writes store the same byte, so the array is unchanged; no special case.
//  kidx is a wrap counter; no divider or modulo operator.
//  start outside IDLE is ignored.
//  start still high in the IDLE cycle after DONE begins a new run; upstream must drive a pulse.
//  secret_key changes after acceptance have no effect until the next start.
//  Reset mid-run: immediate return to IDLE with all outputs low.
//  RAM contents are left partially shuffled; a new init pass is required.
// STRUCTURE
//  rc4_pkg (shared with the init and decrypt stages):
//   - typedef logic [7:0] byte_t
//   - KEY_LEN_DEFAULT = 3
//   - enum ksa_state_t {IDLE, RD_I, WAIT_I, GET_I, RD_J, WAIT_J, GET_J, WR_I, WR_J, DONE}
//  One sub-module: key_byte_sel (KEY_LEN-way byte mux of key_r by kidx, combinational).
//  FSM and datapath stay in ksa_shuffle.
// TESTING
//  Bench models a 256x8 RAM with 1-cycle read latency, preloaded S[k]=k.
//  1 key 24'h000249, pulse start -> after i=0: no change (j=0);
//    after i=1: S[1]=8'h03, S[3]=8'h01, j=3;
//    after i=2: S[2]=8'h4E, S[8'h4E]=8'h02.
//  2 full run -> complete is a single-cycle pulse 2049 cycles after the start edge; 512 wren cycles counted;
//    final RAM equals the software KSA reference and is a permutation of 0..255.
//  3 key 24'h000000 -> final S matches the software model; the kidx wrap sequence is 0,1,2,0,...
//    on every iteration.
//  4 start re-pulsed during cycle 500 and secret_key changed mid-run -> no effect;
//    final RAM matches the original key.
//  5 reset asserted asynchronously at cycle 1000 -> outputs 0 within the same cycle, state IDLE;
//    re-init then start -> correct final S.
//  6 key forcing j==i (e.g. S[0]=0, key byte 0 = 8'h00) -> WR_I/WR_J write the same value;
//    array unchanged at that index.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared RC4 types and constants used by the init, key-scheduling and decrypt stages.
package rc4_pkg;

  typedef logic [7:0] byte_t;

  localparam int KEY_LEN_DEFAULT = 3;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    RD_I   = 4'd1,
    WAIT_I = 4'd2,
    GET_I  = 4'd3,
    RD_J   = 4'd4,
    WAIT_J = 4'd5,
    GET_J  = 4'd6,
    WR_I   = 4'd7,
    WR_J   = 4'd8,
    DONE   = 4'd9
  } ksa_state_t;

  // Width of a counter that indexes KEY_LEN key bytes (at least one bit).
  function automatic int kidx_width(input int key_len);
    return (key_len > 1) ? $clog2(key_len) : 1;
  endfunction

endpackage

// File: rtl/ksa_shuffle_if.sv
// Start/complete handshake plus single-port S RAM bus between the KSA stage and its environment.
interface ksa_shuffle_if #(
  parameter int KEY_LEN = rc4_pkg::KEY_LEN_DEFAULT,
  parameter int ADDR_W  = 8
) ();

  logic                   start;
  logic [8*KEY_LEN-1:0]   secret_key;
  rc4_pkg::byte_t         q;
  logic [ADDR_W-1:0]      address;
  rc4_pkg::byte_t         data;
  logic                   wren;
  logic                   complete;

  modport master (
    input  start, secret_key, q,
    output address, data, wren, complete
  );

  modport slave (
    output start, secret_key, q,
    input  address, data, wren, complete
  );

endinterface

// File: rtl/ksa_shuffle_key_byte_sel.sv
// Selects key byte kidx from the latched key; byte 0 is the most significant byte.
module key_byte_sel
  import rc4_pkg::*;
#(
  parameter int KEY_LEN = KEY_LEN_DEFAULT,
  parameter int KIDX_W  = kidx_width(KEY_LEN)
) (
  input  logic [8*KEY_LEN-1:0] key,
  input  logic [KIDX_W-1:0]    kidx,
  output byte_t                key_byte
);

  byte_t bytes [KEY_LEN];

  // Split the packed key into bytes, MSB first.
  always_comb begin
    for (int k = 0; k < KEY_LEN; k++) begin
      bytes[k] = key[8*(KEY_LEN-k)-1 -: 8];
    end
  end

  assign key_byte = bytes[kidx];

endmodule

// File: rtl/ksa_shuffle.sv
// RC4 key-scheduling stage: swaps S[i] and S[j] for every i using a one-wait-state single-port RAM.
module ksa_shuffle
  import rc4_pkg::*;
#(
  parameter int KEY_LEN = KEY_LEN_DEFAULT,
  parameter int ADDR_W  = 8
) (
  input  logic          clk,
  input  logic          reset,
  ksa_shuffle_if.master bus
);

  localparam int KIDX_W = kidx_width(KEY_LEN);

  ksa_state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0]     i_r, j_r;
  logic [KIDX_W-1:0]     kidx_r;
  byte_t                 si_r, sj_r;
  logic [8*KEY_LEN-1:0]  key_r;
  byte_t                 key_byte_s;
  logic                  last_i_s;

  logic [ADDR_W-1:0]     address_s;
  byte_t                 data_s;
  logic                  wren_s;
  logic                  complete_s;

  key_byte_sel #(.KEY_LEN(KEY_LEN), .KIDX_W(KIDX_W)) u_key_byte_sel (
    .key      (key_r),
    .kidx     (kidx_r),
    .key_byte (key_byte_s)
  );

  assign last_i_s = (i_r == {ADDR_W{1'b1}});

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; every state except IDLE lasts exactly one cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (bus.start) state_nxt_s = RD_I; else state_nxt_s = IDLE;
      RD_I:    state_nxt_s = WAIT_I;
      WAIT_I:  state_nxt_s = GET_I;
      GET_I:   state_nxt_s = RD_J;
      RD_J:    state_nxt_s = WAIT_J;
      WAIT_J:  state_nxt_s = GET_J;
      GET_J:   state_nxt_s = WR_I;
      WR_I:    state_nxt_s = WR_J;
      WR_J:    if (last_i_s) state_nxt_s = DONE; else state_nxt_s = RD_I;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Index, key and swap-operand registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_r    <= '0;
      j_r    <= '0;
      kidx_r <= '0;
      si_r   <= 8'h00;
      sj_r   <= 8'h00;
      key_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            key_r  <= bus.secret_key;
            i_r    <= '0;
            j_r    <= '0;
            kidx_r <= '0;
          end
        end
        GET_I: begin
          si_r <= bus.q;
          j_r  <= j_r + ADDR_W'(bus.q) + ADDR_W'(key_byte_s);
        end
        GET_J: sj_r <= bus.q;
        WR_J: begin
          if (!last_i_s) begin
            i_r    <= i_r + ADDR_W'(1);
            // Wrap counter keeps kidx == i mod KEY_LEN without a divider.
            kidx_r <= (kidx_r == KIDX_W'(KEY_LEN - 1)) ? '0 : kidx_r + KIDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // RAM bus decode from registered state only, so q has no combinational path to the outputs.
  always_comb begin
    address_s  = '0;
    data_s     = 8'h00;
    wren_s     = 1'b0;
    complete_s = 1'b0;
    case (state_r)
      RD_I, WAIT_I: address_s = i_r;
      RD_J, WAIT_J: address_s = j_r;
      WR_I: begin
        address_s = i_r;
        data_s    = sj_r;
        wren_s    = 1'b1;
      end
      WR_J: begin
        address_s = j_r;
        data_s    = si_r;
        wren_s    = 1'b1;
      end
      DONE:    complete_s = 1'b1;
      default: ;
    endcase
  end

  assign bus.address  = address_s;
  assign bus.data     = data_s;
  assign bus.wren     = wren_s;
  assign bus.complete = complete_s;

endmodule

// File: tb/tb_ksa_shuffle.sv
// Self-checking bench for ksa_shuffle: 1-cycle-latency RAM model plus a software RC4 KSA reference.
module tb_ksa_shuffle;
  import rc4_pkg::*;

  localparam int KEY_LEN = 3;
  localparam int ADDR_W  = 8;
  localparam int N       = 256;
  localparam int RUN_CYC = 2060;

  logic clk = 1'b0;
  logic reset;
  logic ram_init;
  always #5 clk = ~clk;

  ksa_shuffle_if #(.KEY_LEN(KEY_LEN), .ADDR_W(ADDR_W)) bus ();

  ksa_shuffle #(.KEY_LEN(KEY_LEN), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] mem [N];

  // Single-port RAM: write on wren, registered read data (one wait state).
  always @(posedge clk) begin
    if (ram_init) begin
      for (int k = 0; k < N; k++) mem[k] <= 8'(k);
    end else if (bus.wren) begin
      mem[bus.address] <= bus.data;
    end
    bus.q <= mem[bus.address];
  end

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_s [N];
  logic [7:0] exp_wa [$];
  logic [7:0] exp_wd [$];
  logic [7:0] obs_wa [$];
  logic [7:0] obs_wd [$];
  int         obs_kidx [$];
  logic [7:0] snap [N];
  int         done_cycle, n_complete, n_wren;

  // Reference RC4 KSA; also records the write stream the hardware should produce.
  task automatic build_model(input logic [23:0] key);
    logic [7:0] s [N];
    logic [7:0] j, t, kb;
    for (int k = 0; k < N; k++) s[k] = 8'(k);
    j = 8'h00;
    exp_wa.delete();
    exp_wd.delete();
    for (int i = 0; i < N; i++) begin
      kb = 8'(key >> (8 * (KEY_LEN - 1 - (i % KEY_LEN))));
      j  = j + s[i] + kb;
      exp_wa.push_back(8'(i)); exp_wd.push_back(s[j]);
      exp_wa.push_back(j);     exp_wd.push_back(s[i]);
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    exp_s = s;
  endtask

  task automatic load_ram();
    @(negedge clk); ram_init = 1'b1;
    @(negedge clk); ram_init = 1'b0;
  endtask

  // Pulse start and log bus activity for a fixed window; cycle 1 is the cycle after the accept edge.
  task automatic run_ksa(input logic [23:0] key, input int pulse_at, input logic [23:0] alt_key);
    obs_wa.delete(); obs_wd.delete(); obs_kidx.delete();
    done_cycle = -1; n_complete = 0; n_wren = 0;
    @(negedge clk);
    bus.secret_key = key;
    bus.start = 1'b1;
    for (int c = 1; c <= RUN_CYC; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (c == pulse_at) begin bus.start = 1'b1; bus.secret_key = alt_key; end
      if (c == pulse_at + 1) bus.start = 1'b0;
      if (bus.wren) begin
        n_wren++;
        obs_wa.push_back(bus.address);
        obs_wd.push_back(bus.data);
      end
      if (bus.complete) begin
        n_complete++;
        if (done_cycle < 0) done_cycle = c;
      end
      if (dut.state_r == RD_I) obs_kidx.push_back(int'(dut.kidx_r));
      if (c == 25) snap = mem;
    end
  endtask

  function automatic int count_ram_diffs();
    int d = 0;
    for (int k = 0; k < N; k++) if (mem[k] !== exp_s[k]) d++;
    return d;
  endfunction

  function automatic int count_write_diffs();
    int d = 0;
    if (obs_wa.size() != exp_wa.size()) return 9999;
    for (int k = 0; k < obs_wa.size(); k++)
      if (obs_wa[k] !== exp_wa[k] || obs_wd[k] !== exp_wd[k]) d++;
    return d;
  endfunction

  task automatic test_reset();
    n_cmp++; if (bus.address !== 8'h00) begin n_err++; $display("FAIL reset_address: got %h want 00", bus.address); end
    n_cmp++; if (bus.data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", bus.data); end
    n_cmp++; if (bus.wren !== 1'b0) begin n_err++; $display("FAIL reset_wren: got %b want 0", bus.wren); end
    n_cmp++; if (bus.complete !== 1'b0) begin n_err++; $display("FAIL reset_complete: got %b want 0", bus.complete); end
  endtask

  task automatic test_known_key();
    load_ram();
    run_ksa(24'h000249, 0, 24'h000000);
    n_cmp++; if (snap[0] !== 8'h00) begin n_err++; $display("FAIL known_s0: got %h want 00", snap[0]); end
    n_cmp++; if (snap[1] !== 8'h03) begin n_err++; $display("FAIL known_s1: got %h want 03", snap[1]); end
    n_cmp++; if (snap[3] !== 8'h01) begin n_err++; $display("FAIL known_s3: got %h want 01", snap[3]); end
    n_cmp++; if (snap[2] !== 8'h4E) begin n_err++; $display("FAIL known_s2: got %h want 4e", snap[2]); end
    n_cmp++; if (snap[8'h4E] !== 8'h02) begin n_err++; $display("FAIL known_s4e: got %h want 02", snap[8'h4E]); end
  endtask

  task automatic test_full_run();
    logic [23:0] key;
    int seen [N];
    int distinct;
    for (int r = 0; r < 2; r++) begin
      key = 24'($urandom);
      load_ram();
      build_model(key);
      run_ksa(key, 0, 24'h000000);
      n_cmp++; if (done_cycle != 2049) begin n_err++; $display("FAIL full_done_cycle: got %0d want 2049", done_cycle); end
      n_cmp++; if (n_complete != 1) begin n_err++; $display("FAIL full_complete_width: got %0d want 1", n_complete); end
      n_cmp++; if (n_wren != 512) begin n_err++; $display("FAIL full_wren_count: got %0d want 512", n_wren); end
      n_cmp++; if (count_write_diffs() != 0) begin n_err++; $display("FAIL full_write_stream key=%h: bad writes %0d want 0", key, count_write_diffs()); end
      n_cmp++; if (count_ram_diffs() != 0) begin n_err++; $display("FAIL full_final_ram key=%h: bad bytes %0d want 0", key, count_ram_diffs()); end
      for (int k = 0; k < N; k++) seen[k] = 0;
      for (int k = 0; k < N; k++) seen[mem[k]] = 1;
      distinct = 0;
      for (int k = 0; k < N; k++) distinct += seen[k];
      n_cmp++; if (distinct != N) begin n_err++; $display("FAIL full_permutation: got %0d distinct want 256", distinct); end
    end
  endtask

  task automatic test_zero_key();
    int bad = 0;
    load_ram();
    build_model(24'h000000);
    run_ksa(24'h000000, 0, 24'h000000);
    n_cmp++; if (count_ram_diffs() != 0) begin n_err++; $display("FAIL zero_final_ram: bad bytes %0d want 0", count_ram_diffs()); end
    for (int k = 0; k < obs_kidx.size(); k++) if (obs_kidx[k] != k % KEY_LEN) bad++;
    n_cmp++; if (obs_kidx.size() != N || bad != 0) begin n_err++; $display("FAIL zero_kidx_seq: got %0d iters %0d bad want 256 iters 0 bad", obs_kidx.size(), bad); end
  endtask

  task automatic test_restart_ignored();
    logic [23:0] key;
    key = 24'($urandom);
    load_ram();
    build_model(key);
    run_ksa(key, 500, ~key);
    n_cmp++; if (done_cycle != 2049) begin n_err++; $display("FAIL restart_done_cycle: got %0d want 2049", done_cycle); end
    n_cmp++; if (count_write_diffs() != 0) begin n_err++; $display("FAIL restart_write_stream: bad writes %0d want 0", count_write_diffs()); end
    n_cmp++; if (count_ram_diffs() != 0) begin n_err++; $display("FAIL restart_final_ram: bad bytes %0d want 0", count_ram_diffs()); end
  endtask

  task automatic test_reset_mid_run();
    logic [23:0] key;
    logic wren_before;
    key = 24'($urandom);
    load_ram();
    @(negedge clk);
    bus.secret_key = key;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (999) @(negedge clk);
    wren_before = bus.wren;
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (wren_before !== 1'b1) begin n_err++; $display("FAIL midrst_busy_before: wren %b want 1", wren_before); end
    n_cmp++; if (bus.wren !== 1'b0 || bus.complete !== 1'b0) begin n_err++; $display("FAIL midrst_ctrl: wren %b complete %b want 0 0", bus.wren, bus.complete); end
    n_cmp++; if (bus.address !== 8'h00 || bus.data !== 8'h00) begin n_err++; $display("FAIL midrst_bus: addr %h data %h want 00 00", bus.address, bus.data); end
    n_cmp++; if (dut.state_r !== IDLE) begin n_err++; $display("FAIL midrst_state: got %0d want IDLE", dut.state_r); end
    @(negedge clk);
    reset = 1'b0;
    key = 24'($urandom);
    load_ram();
    build_model(key);
    run_ksa(key, 0, 24'h000000);
    n_cmp++; if (count_ram_diffs() != 0 || done_cycle != 2049) begin n_err++; $display("FAIL midrst_rerun: bad bytes %0d done %0d want 0 2049", count_ram_diffs(), done_cycle); end
  endtask

  task automatic test_j_equals_i();
    logic [23:0] key;
    key = {8'h00, 16'($urandom)};
    load_ram();
    build_model(key);
    run_ksa(key, 0, 24'h000000);
    n_cmp++; if (obs_wa.size() < 2 || obs_wa[0] !== 8'h00 || obs_wa[1] !== 8'h00) begin n_err++; $display("FAIL jeqi_addr: got %0d writes, first addrs %h %h want 00 00", obs_wa.size(), obs_wa.size() > 0 ? obs_wa[0] : 8'hxx, obs_wa.size() > 1 ? obs_wa[1] : 8'hxx); end
    n_cmp++; if (obs_wd.size() < 2 || obs_wd[0] !== 8'h00 || obs_wd[1] !== 8'h00) begin n_err++; $display("FAIL jeqi_data: first data %h %h want 00 00", obs_wd.size() > 0 ? obs_wd[0] : 8'hxx, obs_wd.size() > 1 ? obs_wd[1] : 8'hxx); end
    n_cmp++; if (count_ram_diffs() != 0) begin n_err++; $display("FAIL jeqi_final_ram: bad bytes %0d want 0", count_ram_diffs()); end
  endtask

  initial begin
    reset = 1'b1;
    ram_init = 1'b0;
    bus.start = 1'b0;
    bus.secret_key = 24'h000000;
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_known_key();
    test_full_run();
    test_zero_key();
    test_restart_ignored();
    test_reset_mid_run();
    test_j_equals_i();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
